// File: rtl/tetris_pkg.sv
// Shared board constants and state codes for the tetris game blocks.
//   BOARD_COLS/BOARD_ROWS : board geometry, cell addr = row*COLS+col, row 0 = top
//   COLOR_W               : colour word width, EMPTY (0) marks an empty cell
//   RAM_AW                : board colour RAM address width
//   game_state_t          : top-level game phases shared by game FSM and colour generator
//   lc_state_t            : line-clear controller sequencing states
package tetris_pkg;

  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned COLOR_W    = 24;
  localparam int unsigned RAM_AW     = 8;
  localparam int unsigned LINES_W    = 5;
  localparam int unsigned ROW_W      = 5;

  localparam logic [COLOR_W-1:0] EMPTY = '0;

  typedef enum logic [2:0] {
    START_SCREEN = 3'd0,
    NEW_PIECE    = 3'd1,
    PLAY         = 3'd2,
    DISTROY_LINE = 3'd3,
    CLEAN        = 3'd4,
    LINES_DOWN   = 3'd5,
    FAIL         = 3'd6
  } game_state_t;

  typedef enum logic [2:0] {
    LC_IDLE  = 3'd0,
    LC_SCAN  = 3'd1,
    LC_CHECK = 3'd2,
    LC_COPY  = 3'd3,
    LC_FILL  = 3'd4,
    LC_DONE  = 3'd5
  } lc_state_t;

endpackage

// File: rtl/line_clear_controller.sv
// Removes full rows from the board colour RAM and compacts survivors downward.
// Scans rows bottom-up into a row buffer, copies each surviving row to the
// lowest free destination row, then zero-fills the rows left at the top.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : 1-cycle request (ignored while busy)
//   busy, done        : run in progress / 1-cycle completion pulse
//   lines_cleared     : full rows removed in the last run
//   ram_addr          : aux-port address, holds while strobes are low
//   ram_rd_en         : read strobe, ram_rdata valid one cycle later
//   ram_rdata         : read data
//   ram_wr_en         : write strobe
//   ram_wdata         : write data
module line_clear_controller
  import tetris_pkg::*;
#(
  parameter int unsigned COLS = BOARD_COLS,
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned CW   = COLOR_W,
  parameter int unsigned AW   = RAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LINES_W-1:0] lines_cleared,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_rd_en,
  input  logic [CW-1:0]      ram_rdata,
  output logic               ram_wr_en,
  output logic [CW-1:0]      ram_wdata
);

  localparam int unsigned CNT_W = $clog2(COLS + 1);
  localparam int unsigned IDX_W = $clog2(COLS);

  localparam logic [AW-1:0]    LAST_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0]    ROW_STEP  = AW'(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] COL_END   = CNT_W'(COLS);

  lc_state_t          r_state;
  logic [ROW_W-1:0]   r_src;
  logic [ROW_W-1:0]   r_dst;
  logic [AW-1:0]      r_src_base;
  logic [AW-1:0]      r_dst_base;
  logic [CNT_W-1:0]   r_col;
  logic               r_full;
  logic [CW-1:0]      r_buf [COLS];
  logic [LINES_W-1:0] r_lines;
  logic               r_busy;
  logic               r_done;
  logic [AW-1:0]      r_ram_addr;
  logic               r_ram_rd_en;
  logic               r_ram_wr_en;
  logic [CW-1:0]      r_ram_wdata;

  logic [CNT_W-1:0]   w_col_inc;
  logic               w_exit;
  logic [LINES_W-1:0] w_exit_lines;
  logic [AW-1:0]      w_exit_dst_base;

  assign w_col_inc = r_col + CNT_W'(1);

  // Row-finished decision shared by CHECK and the last COPY cycle; carries the
  // line count and destination base as they will be after this cycle.
  always_comb begin
    w_exit          = 1'b0;
    w_exit_lines    = r_lines;
    w_exit_dst_base = r_dst_base;
    case (r_state)
      LC_CHECK: begin
        w_exit = r_full || (r_src == r_dst);
        if (r_full) begin
          w_exit_lines = r_lines + LINES_W'(1);
        end else if (r_dst != '0) begin
          w_exit_dst_base = r_dst_base - ROW_STEP;
        end
      end
      LC_COPY: begin
        w_exit          = (r_col == COL_LAST);
        w_exit_dst_base = r_dst_base - ROW_STEP;
      end
      default: ;
    endcase
  end

  // Sequencer: all outputs are registered and set up one cycle ahead of the
  // state that uses them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LC_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_col       <= '0;
      r_full      <= 1'b0;
      r_lines     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_rd_en <= 1'b0;
      r_ram_wr_en <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_rd_en <= 1'b0;
      r_ram_wr_en <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        LC_IDLE: begin
          if (start) begin
            r_state     <= LC_SCAN;
            r_busy      <= 1'b1;
            r_lines     <= '0;
            r_src       <= LAST_ROW;
            r_dst       <= LAST_ROW;
            r_src_base  <= LAST_BASE;
            r_dst_base  <= LAST_BASE;
            r_col       <= '0;
            r_full      <= 1'b1;
            r_ram_rd_en <= 1'b1;
            r_ram_addr  <= LAST_BASE;
          end
        end

        // Issue COLS reads; capture lags one cycle behind the address.
        LC_SCAN: begin
          if (r_col != '0) begin
            r_buf[IDX_W'(r_col - CNT_W'(1))] <= ram_rdata;
            if (ram_rdata == CW'(EMPTY)) begin
              r_full <= 1'b0;
            end
          end
          if (r_col == COL_END) begin
            r_state <= LC_CHECK;
            r_col   <= '0;
          end else begin
            r_col <= w_col_inc;
            if (r_col < COL_LAST) begin
              r_ram_rd_en <= 1'b1;
              r_ram_addr  <= r_src_base + AW'(w_col_inc);
            end
          end
        end

        LC_CHECK: begin
          r_lines <= w_exit_lines;
          if (!r_full && (r_src != r_dst)) begin
            r_state     <= LC_COPY;
            r_col       <= '0;
            r_ram_wr_en <= 1'b1;
            r_ram_addr  <= r_dst_base;
            r_ram_wdata <= r_buf[0];
          end else if (!r_full && (r_dst != '0)) begin
            r_dst      <= r_dst - ROW_W'(1);
            r_dst_base <= w_exit_dst_base;
          end
        end

        LC_COPY: begin
          if (r_col != COL_LAST) begin
            r_col       <= w_col_inc;
            r_ram_wr_en <= 1'b1;
            r_ram_addr  <= r_dst_base + AW'(w_col_inc);
            r_ram_wdata <= r_buf[IDX_W'(w_col_inc)];
          end else begin
            r_dst      <= r_dst - ROW_W'(1);
            r_dst_base <= w_exit_dst_base;
          end
        end

        // Zero rows dst..0, which are the rows vacated by removed lines.
        LC_FILL: begin
          if (r_col != COL_LAST) begin
            r_col       <= w_col_inc;
            r_ram_wr_en <= 1'b1;
            r_ram_addr  <= r_dst_base + AW'(w_col_inc);
            r_ram_wdata <= CW'(EMPTY);
          end else if (r_dst == '0) begin
            r_state <= LC_DONE;
            r_done  <= 1'b1;
          end else begin
            r_dst       <= r_dst - ROW_W'(1);
            r_dst_base  <= r_dst_base - ROW_STEP;
            r_col       <= '0;
            r_ram_wr_en <= 1'b1;
            r_ram_addr  <= r_dst_base - ROW_STEP;
            r_ram_wdata <= CW'(EMPTY);
          end
        end

        LC_DONE: begin
          r_state <= LC_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= LC_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Row finished: scan the next row up, or finish with an optional fill.
      if (w_exit) begin
        if (r_src == '0) begin
          if (w_exit_lines != '0) begin
            r_state     <= LC_FILL;
            r_col       <= '0;
            r_ram_wr_en <= 1'b1;
            r_ram_addr  <= w_exit_dst_base;
            r_ram_wdata <= CW'(EMPTY);
          end else begin
            r_state <= LC_DONE;
            r_done  <= 1'b1;
          end
        end else begin
          r_state     <= LC_SCAN;
          r_src       <= r_src - ROW_W'(1);
          r_src_base  <= r_src_base - ROW_STEP;
          r_col       <= '0;
          r_full      <= 1'b1;
          r_ram_rd_en <= 1'b1;
          r_ram_addr  <= r_src_base - ROW_STEP;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign lines_cleared = r_lines;
  assign ram_addr      = r_ram_addr;
  assign ram_rd_en     = r_ram_rd_en;
  assign ram_wr_en     = r_ram_wr_en;
  assign ram_wdata     = r_ram_wdata;

endmodule

// File: tb/tb_line_clear_controller.sv
// Bench for line_clear_controller: behavioural RAM with 1-cycle read latency,
// a board-level reference model (drop full rows, pack survivors to the bottom)
// and per-cycle checks of busy/done/strobe exclusivity during each run.
module tb_line_clear_controller;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CELLS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  lines_cleared;
  logic [7:0]  ram_addr;
  logic        ram_rd_en;
  logic [23:0] ram_rdata = '0;
  logic        ram_wr_en;
  logic [23:0] ram_wdata;

  logic [23:0] mem      [CELLS];
  logic [23:0] init_mem [CELLS];
  logic [23:0] exp_mem  [CELLS];
  logic        load_req = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_lines;
  int exp_lat;
  int exp_writes;
  int last_n;

  line_clear_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .ram_addr     (ram_addr),
    .ram_rd_en    (ram_rd_en),
    .ram_rdata    (ram_rdata),
    .ram_wr_en    (ram_wr_en),
    .ram_wdata    (ram_wdata)
  );

  always #5 clk = ~clk;

  // Board RAM aux port plus a bulk-load path used only while the DUT is idle.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= init_mem[i];
    end else begin
      if (ram_wr_en) mem[ram_addr] <= ram_wdata;
      if (ram_rd_en) ram_rdata <= mem[ram_addr];
    end
    if (ram_wr_en) wr_cnt <= wr_cnt + 1;
    if (ram_rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_init();
    for (int i = 0; i < CELLS; i++) init_mem[i] = '0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < COLS; c++) init_mem[r*COLS+c] = 24'h100000 + 24'(r*16 + c + 1);
  endtask

  task automatic load_board();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Reference: survivors keep their order and stack from the bottom; the
  // rows above them are empty. Timing follows the per-row phase costs.
  task automatic build_model();
    int  dst;
    int  copies;
    bit  full;
    exp_lines = 0;
    copies    = 0;
    dst       = ROWS - 1;
    for (int i = 0; i < CELLS; i++) exp_mem[i] = mem[i];
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mem[r*COLS+c] == 24'h0) full = 1'b0;
      if (full) exp_lines++;
      else begin
        if (dst != r) copies++;
        for (int c = 0; c < COLS; c++) exp_mem[dst*COLS+c] = mem[r*COLS+c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) exp_mem[r*COLS+c] = '0;
    exp_lat    = ROWS*(COLS+2) + COLS*copies + COLS*exp_lines + 1;
    exp_writes = COLS*(copies + exp_lines);
  endtask

  task automatic run_case(input string name, input bit poke_start);
    int n;
    bit seen;
    int rd0;
    int wr0;
    int bad_cells;
    int first_bad;
    build_model();
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    check({name, ":busy_idle"}, 64'(busy), 64'd0);
    start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < exp_lat + 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = poke_start && (n == 4 || n == exp_lat / 2);
      check({name, ":busy"}, 64'(busy), 64'(n <= exp_lat));
      check({name, ":done"}, 64'(done), 64'(n == exp_lat));
      check({name, ":rd_wr_excl"}, 64'(ram_rd_en && ram_wr_en), 64'd0);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    last_n = n;
    check({name, ":done_seen"}, 64'(seen), 64'd1);
    check({name, ":latency"}, 64'(n), 64'(exp_lat));
    check({name, ":lines"}, 64'(lines_cleared), 64'(exp_lines));
    check({name, ":writes"}, 64'(wr_cnt - wr0), 64'(exp_writes));
    check({name, ":reads"}, 64'(rd_cnt - rd0), 64'(ROWS*COLS));
    bad_cells = 0;
    first_bad = -1;
    for (int i = 0; i < CELLS; i++)
      if (mem[i] !== exp_mem[i]) begin
        bad_cells++;
        if (first_bad < 0) first_bad = i;
      end
    check({name, ":ram_bad_cells"}, 64'(bad_cells), 64'd0);
    if (first_bad >= 0)
      $display("  first differing cell %0d: ram %0h model %0h", first_bad, mem[first_bad], exp_mem[first_bad]);
    repeat (3) @(negedge clk);
    check({name, ":busy_after"}, 64'(busy), 64'd0);
    check({name, ":done_after"}, 64'(done), 64'd0);
    check({name, ":lines_hold"}, 64'(lines_cleared), 64'(exp_lines));
  endtask

  initial begin
    int w_snap;
    int r_snap;
    bit got;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(ram_rd_en), 64'd0);
    check("rst_wr_en", 64'(ram_wr_en), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    check("rst_lines", 64'(lines_cleared), 64'd0);
    reset = 1'b0;

    // 1: empty board
    clear_init();
    load_board();
    run_case("empty", 1'b0);
    check("empty_lat_lit", 64'(last_n), 64'd241);
    check("empty_lines_lit", 64'(lines_cleared), 64'd0);

    // 2: row 19 full, single cell on row 18
    clear_init();
    fill_row(19);
    init_mem[18*COLS+3] = 24'h66B2FF;
    load_board();
    run_case("one_line", 1'b0);
    check("one_line_cell_lit", 64'(mem[193]), 64'h66B2FF);
    check("one_line_row18_lit", 64'(mem[183]), 64'd0);
    check("one_line_lines_lit", 64'(lines_cleared), 64'd1);

    // 3: four full rows at the bottom
    clear_init();
    for (int r = 16; r < 20; r++) fill_row(r);
    load_board();
    run_case("tetris", 1'b0);
    check("tetris_lines_lit", 64'(lines_cleared), 64'd4);
    check("tetris_row19_lit", 64'(mem[195]), 64'd0);

    // 4: interleaved full and partial rows
    clear_init();
    fill_row(19);
    fill_row(17);
    init_mem[18*COLS+0] = 24'h0000A1;
    init_mem[18*COLS+9] = 24'h0000A9;
    init_mem[16*COLS+5] = 24'h0000B5;
    load_board();
    run_case("interleave", 1'b0);
    check("interleave_lines_lit", 64'(lines_cleared), 64'd2);
    check("interleave_r19c0_lit", 64'(mem[190]), 64'hA1);
    check("interleave_r19c9_lit", 64'(mem[199]), 64'hA9);
    check("interleave_r18c5_lit", 64'(mem[185]), 64'hB5);
    check("interleave_r17c5_lit", 64'(mem[175]), 64'd0);

    // 5: every cell occupied
    clear_init();
    for (int r = 0; r < ROWS; r++) fill_row(r);
    load_board();
    run_case("all_full", 1'b0);
    check("all_full_lines_lit", 64'(lines_cleared), 64'd20);
    check("all_full_r0_lit", 64'(mem[0]), 64'd0);
    check("all_full_lat_lit", 64'(last_n), 64'd441);

    // Full row high up with partial rows below it: only rows above move
    clear_init();
    fill_row(5);
    init_mem[19*COLS+1] = 24'h000C01;
    init_mem[4*COLS+7]  = 24'h000C47;
    load_board();
    run_case("mid_line", 1'b0);
    check("mid_line_lat_lit", 64'(last_n), 64'd301);
    check("mid_line_r19_lit", 64'(mem[191]), 64'hC01);
    check("mid_line_r5_lit", 64'(mem[57]), 64'hC47);

    // 6a: start pulses while busy must be ignored
    clear_init();
    fill_row(19);
    init_mem[18*COLS+3] = 24'h66B2FF;
    load_board();
    run_case("start_poke", 1'b1);

    // 6b: reset in the middle of a row copy
    clear_init();
    fill_row(19);
    init_mem[18*COLS+3] = 24'h66B2FF;
    load_board();
    @(negedge clk);
    start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (ram_wr_en) got = 1'b1;
    end
    check("rst_mid_reach_copy", 64'(got), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_wr_en", 64'(ram_wr_en), 64'd0);
    check("rst_mid_rd_en", 64'(ram_rd_en), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_lines", 64'(lines_cleared), 64'd0);
    w_snap = wr_cnt;
    r_snap = rd_cnt;
    repeat (2) @(negedge clk);
    check("rst_mid_no_wr", 64'(wr_cnt), 64'(w_snap));
    check("rst_mid_no_rd", 64'(rd_cnt), 64'(r_snap));
    reset = 1'b0;
    run_case("after_reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
